// File: rtl/pixel_split_wr.sv
// pixel_split_wr: packs pairs of 24-bit RGB pixels into three 16-bit
// SDRAM write-FIFO words and marks frame start/end for the writer.
//
// Ports:
//   clk_ref      - sole clock (sdram controller domain)
//   rst          - synchronous active-high reset
//   pix_valid    - source pixel valid
//   pix_data     - pixel {R,G,B}
//   pix_sof      - first pixel of a frame (qualified by pix_valid)
//   pix_ready    - pixel accepted this cycle when high with pix_valid
//   wr_afull     - write FIFO almost full, stalls word emission
//   sys_we       - write FIFO write enable (registered)
//   sys_data_in  - write FIFO data (registered)
//   wr_load      - 1-cycle pulse, restart SDRAM write address
//   frame_done   - 1-cycle pulse with the last word of a frame
//   drop_cnt     - saturating count of unpaired pixels dropped on sof
//
// Build option: define PIX_SPLIT_DROPCNT_EN to enable the drop counter;
// otherwise drop_cnt is tied to zero.

module pixel_split_wr #(
    parameter int PIX_PER_FRAME = 130560,
    parameter int CNT_W         = 18,
    parameter int DROP_W        = 8
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    input  logic              pix_sof,
    output logic              pix_ready,
    input  logic              wr_afull,
    output logic              sys_we,
    output logic [15:0]       sys_data_in,
    output logic              wr_load,
    output logic              frame_done,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_P0, S_P1, S_W0, S_W1, S_W2
    } state_t;

    state_t state_q, state_d;

    logic [23:0]      p0_q, p0_d;
    logic [23:0]      p1_q, p1_d;
    logic             in_frame_q, in_frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_q, last_d;
    logic             we_q, we_d;
    logic [15:0]      data_q, data_d;
    logic             load_q, load_d;
    logic             done_q, done_d;
    logic             xfer;

    assign pix_ready = ~rst & ((state_q == S_P0) | (state_q == S_P1));
    assign xfer      = pix_valid & pix_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        in_frame_d = in_frame_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        we_d       = 1'b0;
        data_d     = data_q;
        load_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_P0: begin
                if (xfer) begin
                    if (pix_sof) begin
                        p0_d       = pix_data;
                        in_frame_d = 1'b1;
                        cnt_d      = CNT_W'(1);
                        load_d     = 1'b1;
                        state_d    = S_P1;
                    end else if (in_frame_q) begin
                        p0_d    = pix_data;
                        cnt_d   = cnt_inc;
                        state_d = S_P1;
                    end
                end
            end
            S_P1: begin
                if (xfer) begin
                    if (pix_sof) begin
                        // held p0 belongs to an aborted frame
                        p0_d   = pix_data;
                        cnt_d  = CNT_W'(1);
                        load_d = 1'b1;
                    end else begin
                        p1_d    = pix_data;
                        cnt_d   = cnt_inc;
                        last_d  = (cnt_inc == CNT_W'(PIX_PER_FRAME));
                        state_d = S_W0;
                    end
                end
            end
            S_W0: begin
                if (!wr_afull) begin
                    we_d    = 1'b1;
                    data_d  = p0_q[23:8];
                    state_d = S_W1;
                end
            end
            S_W1: begin
                if (!wr_afull) begin
                    we_d    = 1'b1;
                    data_d  = {p0_q[7:0], p1_q[23:16]};
                    state_d = S_W2;
                end
            end
            S_W2: begin
                if (!wr_afull) begin
                    we_d    = 1'b1;
                    data_d  = p1_q[15:0];
                    state_d = S_P0;
                    if (last_q) begin
                        done_d     = 1'b1;
                        in_frame_d = 1'b0;
                        last_d     = 1'b0;
                    end
                end
            end
            default: state_d = S_P0;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q    <= S_P0;
            p0_q       <= '0;
            p1_q       <= '0;
            in_frame_q <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            we_q       <= 1'b0;
            data_q     <= '0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            in_frame_q <= in_frame_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            we_q       <= we_d;
            data_q     <= data_d;
            load_q     <= load_d;
            done_q     <= done_d;
        end
    end

    assign sys_we      = we_q;
    assign sys_data_in = data_q;
    assign wr_load     = load_q;
    assign frame_done  = done_q;

`ifdef PIX_SPLIT_DROPCNT_EN
    logic              drop_inc;
    logic [DROP_W-1:0] drop_q;

    assign drop_inc = xfer & pix_sof & (state_q == S_P1);

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop_inc && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_split_wr.sv
// tb_pixel_split_wr: directed stimulus with a queue-based scoreboard;
// a negedge monitor pops expected words/pulses as the DUT emits them.

module tb_pixel_split_wr;

    localparam int PPF = 8;

    logic        clk_ref = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        pix_ready;
    logic        wr_afull = 1'b0;
    logic        sys_we;
    logic [15:0] sys_data_in;
    logic        wr_load;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    pixel_split_wr #(
        .PIX_PER_FRAME(PPF),
        .CNT_W(18),
        .DROP_W(8)
    ) dut (
        .clk_ref(clk_ref),
        .rst(rst),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .pix_ready(pix_ready),
        .wr_afull(wr_afull),
        .sys_we(sys_we),
        .sys_data_in(sys_data_in),
        .wr_load(wr_load),
        .frame_done(frame_done),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    typedef struct {
        logic [15:0] d;
        logic        fd;
        int          c;
    } exp_t;

    exp_t wq[$];
    int   ldq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   we_cnt = 0;
    int   ld_cnt = 0;
    int   fd_cnt = 0;

    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cyc %0d)",
                      name, act, exp, cyc);
    endtask

    always @(negedge clk_ref) begin
        if (sys_we) begin
            exp_t e;
            we_cnt++;
            chk("we_expected", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("we_data", 32'(sys_data_in), 32'(e.d));
                chk("we_cyc", cyc, e.c);
                chk("we_fdone", 32'(frame_done), 32'(e.fd));
            end
        end else if (frame_done) begin
            chk("fdone_without_we", 32'(sys_we), 1);
        end
        if (frame_done) fd_cnt++;
        if (wr_load) begin
            ld_cnt++;
            chk("ld_fd_excl", 32'(frame_done), 0);
            chk("ld_expected", 32'(ldq.size() != 0), 1);
            if (ldq.size() != 0) chk("ld_cyc", cyc, ldq.pop_front());
        end
    end

    // returns edge index at which the pixel transferred
    task automatic send(input logic [23:0] d, input logic sof,
                        output int edge_no);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        while (!pix_ready && n < 50) begin
            @(posedge clk_ref); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(pix_ready), 1);
        @(posedge clk_ref); #1;
        edge_no   = cyc;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic push3(input logic [23:0] a, input logic [23:0] b,
                         input int e, input int stall, input logic fd);
        wq.push_back('{d: a[23:8], fd: 1'b0, c: e + 1});
        wq.push_back('{d: {a[7:0], b[23:16]}, fd: 1'b0,
                       c: e + 2 + stall});
        wq.push_back('{d: b[15:0], fd: fd, c: e + 3 + stall});
    endtask

    task automatic send_pair(input logic [23:0] a, input logic [23:0] b,
                             input logic sof, input logic fd);
        int e;
        send(a, sof, e);
        if (sof) ldq.push_back(e);
        send(b, 1'b0, e);
        push3(a, b, e, 0, fd);
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || ldq.size() != 0) && n < 40) begin
            @(negedge clk_ref);
            n++;
        end
        @(negedge clk_ref);
        chk("drain_words", wq.size(), 0);
        chk("drain_loads", ldq.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        wr_afull = 1'b0;
        repeat (2) @(posedge clk_ref);
        #1;
        chk("rst_we", 32'(sys_we), 0);
        chk("rst_data", 32'(sys_data_in), 0);
        chk("rst_load", 32'(wr_load), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_ready", 32'(pix_ready), 0);
        wq.delete();
        ldq.delete();
        rst = 1'b0;
        @(posedge clk_ref); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        int we0, ld0, fd0;
        logic [23:0] pa, pb;

        // 1: basic pair, back-to-back
        do_reset();
        send(24'hAABBCC, 1'b1, e);
        ldq.push_back(e);
        send(24'h112233, 1'b0, e);
        wq.push_back('{d: 16'hAABB, fd: 1'b0, c: e + 1});
        wq.push_back('{d: 16'hCC11, fd: 1'b0, c: e + 2});
        wq.push_back('{d: 16'h2233, fd: 1'b0, c: e + 3});
        drain();

        // 2: 4-cycle stall while in S_W1
        send(24'hAABBCC, 1'b1, e);
        ldq.push_back(e);
        send(24'h112233, 1'b0, e);
        wq.push_back('{d: 16'hAABB, fd: 1'b0, c: e + 1});
        wq.push_back('{d: 16'hCC11, fd: 1'b0, c: e + 6});
        wq.push_back('{d: 16'h2233, fd: 1'b0, c: e + 7});
        @(posedge clk_ref); #1;
        wr_afull = 1'b1;
        repeat (4) @(posedge clk_ref);
        #1;
        wr_afull = 1'b0;
        drain();

        // 3: full frame of 8 pixels, then 2 stray pixels
        fd0 = fd_cnt;
        for (int i = 0; i < PPF / 2; i++) begin
            pa = {8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3)};
            pb = {8'(16 * i + 4), 8'(16 * i + 5), 8'(16 * i + 6)};
            send_pair(pa, pb, i == 0, i == PPF / 2 - 1);
        end
        drain();
        chk("frame_done_cnt", fd_cnt - fd0, 1);
        we0 = we_cnt;
        ld0 = ld_cnt;
        send(24'hDEAD01, 1'b0, e);
        send(24'hDEAD02, 1'b0, e);
        repeat (10) @(posedge clk_ref);
        #1;
        chk("post_frame_we", we_cnt - we0, 0);
        chk("post_frame_ld", ld_cnt - ld0, 0);

        // 4: sof, one pixel, sof again -> drop
        do_reset();
        ld0 = ld_cnt;
        send(24'h0F0F0F, 1'b1, e);
        ldq.push_back(e);
        send(24'h445566, 1'b1, e);
        ldq.push_back(e);
        send(24'h778899, 1'b0, e);
        wq.push_back('{d: 16'h4455, fd: 1'b0, c: e + 1});
        wq.push_back('{d: 16'h6677, fd: 1'b0, c: e + 2});
        wq.push_back('{d: 16'h8899, fd: 1'b0, c: e + 3});
        drain();
        chk("sof_sof_loads", ld_cnt - ld0, 2);
`ifdef PIX_SPLIT_DROPCNT_EN
        chk("drop_cnt", 32'(drop_cnt), 1);
`else
        chk("drop_cnt", 32'(drop_cnt), 0);
`endif

        // 5: pixels before any sof
        do_reset();
        we0 = we_cnt;
        ld0 = ld_cnt;
        for (int i = 0; i < 3; i++) begin
            chk("ready_noframe", 32'(pix_ready), 1);
            send(24'h500000 + 24'(i), 1'b0, e);
        end
        repeat (8) @(posedge clk_ref);
        #1;
        chk("noframe_we", we_cnt - we0, 0);
        chk("noframe_ld", ld_cnt - ld0, 0);
        chk("noframe_ready", 32'(pix_ready), 1);

        // 6: reset while in S_W1, then clean burst
        send(24'h123456, 1'b1, e);
        ldq.push_back(e);
        send(24'h789ABC, 1'b0, e);
        wq.push_back('{d: 16'h1234, fd: 1'b0, c: e + 1});
        @(posedge clk_ref); #1;
        rst = 1'b1;
        @(posedge clk_ref); #1;
        chk("midrst_we", 32'(sys_we), 0);
        chk("midrst_data", 32'(sys_data_in), 0);
        chk("midrst_load", 32'(wr_load), 0);
        chk("midrst_fdone", 32'(frame_done), 0);
        chk("midrst_ready", 32'(pix_ready), 0);
        chk("midrst_pending", wq.size(), 0);
        rst = 1'b0;
        @(posedge clk_ref); #1;
        send_pair(24'hCAFE12, 24'h345678, 1'b1, 1'b0);
        drain();
        chk("midrst_drop", 32'(drop_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
